btb_gshare_predictor: RTL and testbench
=======================================

Name: btb_gshare_predictor

Overview:
Parametrised branch predictor for the 5-stage MIPS pipeline. It generalises the fixed bimodal predictor and single branch table into three structures: a tagged direct-mapped branch target buffer (BTB), a separate pattern history table (PHT) of saturating counters, and a selectable bimodal/gshare indexing mode. Lookup is combinational in IF on the fetch PC. Updates and redirect decisions come from the branch resolution stage (MEM, s4).

Parameters:
ENTRIES, 16, BTB and PHT depth; power of 2, 2..64; IDX_BITS = log2(ENTRIES)
TAG_BITS, 8, stored tag width taken from PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
CTR_BITS, 2, PHT saturating counter width, 1..4
MODE, 0, 0 = bimodal (PHT index = PC idx); 1 = gshare (PHT index = PC idx XOR zero-extended GHR)
GHR_BITS, 4, global history length, 1..IDX_BITS; unused when MODE=0

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
fetch_pc  in  32  IF-stage PC (byte address; bits [1:0] ignored)
pred_hit  out  1  BTB valid entry with matching tag
pred_taken  out  1  pred_hit AND PHT counter MSB
pred_target  out  32  BTB target if pred_taken, else fetch_pc+4
pred_ghr  out  GHR_BITS  GHR snapshot; pipeline carries it with the branch
upd_valid  in  1  resolved instruction present in s4 (not flushed)
upd_is_branch  in  1  s4 instruction is beq/bne
upd_pc  in  32  PC of the resolved branch
upd_taken  in  1  actual outcome (deviated_s4)
upd_target  in  32  actual branch target (baddr_s4)
upd_pred_taken  in  1  pred_taken piped from IF
upd_pred_target  in  32  pred_target piped from IF
upd_ghr  in  GHR_BITS  pred_ghr piped from IF
redirect_valid  out  1  mispredict; pipeline flushes s1..s3
redirect_pc  out  32  correct next PC

Behaviour:
- Reset (rst_n=0 at posedge): all BTB valid bits=0; tags and targets=0; every PHT counter=2^(CTR_BITS-1)-1 (weakly not-taken); GHR=0. Reset overrides any same-cycle update.
- Lookup is purely combinational from fetch_pc and current state, so it has zero latency.
  - BTB idx = fetch_pc[IDX_BITS+1:2].
  - PHT index is selected per MODE.
  - On a miss: pred_taken=0 and pred_target=fetch_pc+4.
- Resolution is combinational, with E = upd_valid & upd_is_branch:
  - redirect_valid = E & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - When E=0, redirect_valid=0 and redirect_pc=0.
- Update happens at the posedge when E=1:
  - PHT entry (indexed using upd_pc and upd_ghr, not the live GHR) increments on taken and decrements on not-taken. It saturates at 0 and at 2^CTR_BITS-1. The PHT updates whether or not the BTB hit.
  - BTB hit (valid and tag match at upd_pc index), taken: target rewritten with upd_target.
  - BTB hit, not-taken: BTB entry unchanged.
  - BTB miss, taken: allocate; the entry gets valid=1, tag and target. The victim is replaced unconditionally (direct-mapped).
  - BTB miss, not-taken: no allocation.
  - GHR becomes {GHR[GHR_BITS-2:0], upd_taken} (left shift). The GHR is non-speculative.
- Same-cycle lookup and update of the same entry: lookup returns the pre-update value (read-before-write). The new value is visible on the next cycle.
- Non-branch (upd_is_branch=0) or upd_valid=0: no state change.
- Upstream stall does not affect the predictor. Lookup is stateless and the pipeline registers hold its outputs.

Optional Feature:
Macro BTB_PREDICTOR_STATS_EN.
- Defined: adds outputs stat_branches, stat_mispredicts and stat_btb_misses, each 32-bit.
  - stat_branches increments on E.
  - stat_mispredicts increments on redirect_valid.
  - stat_btb_misses increments on E & BTB miss at upd_pc.
  - All three reset to 0, wrap modulo 2^32, and update on the same edge as the tables.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
1. Post-reset lookup at fetch_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44, pred_ghr=0.
2. Resolve branch upd_pc=0x40, taken, target 0x80, upd_pred_taken=0 -> redirect_valid=1, redirect_pc=0x80. Next cycle lookup 0x40 -> pred_hit=1, counter=2, pred_taken=1, pred_target=0x80.
3. Saturation (CTR_BITS=2, MODE=0): resolve pc 0x40 taken 3 more times -> counter stays 3. Then 2 not-taken -> counter 1, pred_taken=0, pred_target=0x44. The not-taken with upd_pred_taken=1 gives redirect_valid=1, redirect_pc=0x44.
4. Aliasing: allocate 0x40, then resolve taken 0x440 (same idx, ENTRIES=16, different tag) -> lookup 0x40 misses, lookup 0x440 hits with its target.
5. MODE=1, GHR_BITS=4: resolve four taken branches -> pred_ghr=4'hF. PHT index for pc 0x40 = 0x0 XOR 0xF = 0xF, so the update touches PHT[0xF] only.
6. Assert rst_n=0 in the same cycle as an allocating update -> BTB empty and GHR=0 next cycle. With BTB_PREDICTOR_STATS_EN, all stats=0.

Source files
------------

// File: rtl/btb_gshare_predictor.sv
// Branch predictor: tagged direct-mapped BTB, separate PHT of saturating counters, bimodal or gshare indexing.
// Optional BTB_PREDICTOR_STATS_EN adds branch / mispredict / BTB-miss event counters.
module btb_gshare_predictor #(
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 0,
  parameter int GHR_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         fetch_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic                upd_is_branch,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_pred_taken,
  input  logic [31:0]         upd_pred_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc
`ifdef BTB_PREDICTOR_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts,
  output logic [31:0]         stat_btb_misses
`endif
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic                r_btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_btb_tag    [ENTRIES];
  logic [31:0]         r_btb_target [ENTRIES];
  logic [CTR_BITS-1:0] r_pht        [ENTRIES];
  logic [GHR_BITS-1:0] r_ghr;

  function automatic logic [IDX_BITS-1:0] pht_index(input logic [IDX_BITS-1:0] idx,
                                                    input logic [GHR_BITS-1:0] ghr);
    return (MODE == 1) ? (idx ^ IDX_BITS'(ghr)) : idx;
  endfunction

  // Lookup side: purely combinational on fetch_pc and current table state.
  logic [IDX_BITS-1:0] w_f_idx;
  logic [TAG_BITS-1:0] w_f_tag;
  logic [IDX_BITS-1:0] w_f_pht_idx;

  assign w_f_idx     = fetch_pc[IDX_BITS+1:2];
  assign w_f_tag     = fetch_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_f_pht_idx = pht_index(w_f_idx, r_ghr);
  assign pred_hit    = r_btb_valid[w_f_idx] && (r_btb_tag[w_f_idx] == w_f_tag);
  assign pred_taken  = pred_hit && r_pht[w_f_pht_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? r_btb_target[w_f_idx] : fetch_pc + 32'd4;
  assign pred_ghr    = r_ghr;

  // Resolution side: PHT is indexed with the GHR snapshot carried by the branch.
  logic                w_e;
  logic [IDX_BITS-1:0] w_u_idx;
  logic [TAG_BITS-1:0] w_u_tag;
  logic [IDX_BITS-1:0] w_u_pht_idx;
  logic                w_u_hit;
  logic                w_mispredict;
  logic [CTR_BITS-1:0] w_u_ctr;
  logic [CTR_BITS-1:0] w_ctr_next;

  assign w_e          = upd_valid & upd_is_branch;
  assign w_u_idx      = upd_pc[IDX_BITS+1:2];
  assign w_u_tag      = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_u_pht_idx  = pht_index(w_u_idx, upd_ghr);
  assign w_u_hit      = r_btb_valid[w_u_idx] && (r_btb_tag[w_u_idx] == w_u_tag);
  assign w_u_ctr      = r_pht[w_u_pht_idx];
  assign w_mispredict = (upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));

  assign redirect_valid = w_e && w_mispredict;
  assign redirect_pc    = !w_e ? 32'd0 : (upd_taken ? upd_target : upd_pc + 32'd4);

  always_comb begin
    w_ctr_next = w_u_ctr;
    if (upd_taken && (w_u_ctr != CTR_MAX))
      w_ctr_next = w_u_ctr + 1'b1;
    else if (!upd_taken && (w_u_ctr != '0))
      w_ctr_next = w_u_ctr - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb_valid[i]  <= 1'b0;
        r_btb_tag[i]    <= '0;
        r_btb_target[i] <= '0;
        r_pht[i]        <= CTR_INIT;
      end
      r_ghr <= '0;
    end else if (w_e) begin
      r_pht[w_u_pht_idx] <= w_ctr_next;
      // Taken: a hit rewrites the target, a miss evicts whatever lives at this index.
      if (upd_taken) begin
        r_btb_valid[w_u_idx]  <= 1'b1;
        r_btb_tag[w_u_idx]    <= w_u_tag;
        r_btb_target[w_u_idx] <= upd_target;
      end
      r_ghr <= GHR_BITS'({r_ghr, upd_taken});
    end
  end

`ifdef BTB_PREDICTOR_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      stat_btb_misses  <= '0;
    end else begin
      if (w_e)             stat_branches    <= stat_branches + 32'd1;
      if (redirect_valid)  stat_mispredicts <= stat_mispredicts + 32'd1;
      if (w_e && !w_u_hit) stat_btb_misses  <= stat_btb_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_gshare_predictor.sv
// Directed bench for btb_gshare_predictor: a bimodal (dut0) and a gshare (dut1) instance share stimulus.
// Each vector queues its expected lookup/redirect response; a negedge monitor pops and compares.
module tb_btb_gshare_predictor;

  localparam int EXP_W = 72;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        upd_valid, upd_is_branch, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic [3:0]  upd_ghr;

  logic        hit0, tk0, rv0, hit1, tk1, rv1;
  logic [31:0] tgt0, rpc0, tgt1, rpc1;
  logic [3:0]  ghr0, ghr1;
`ifdef BTB_PREDICTOR_STATS_EN
  logic [31:0] sb0, sm0, sx0, sb1, sm1, sx1;
`endif

  logic [EXP_W-1:0] exp_q[$];
  logic             chk_en = 1'b0;
  int               n_cmp = 0;
  int               n_bad = 0;

  always #5 clk = ~clk;

  btb_gshare_predictor #(.MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_hit(hit0), .pred_taken(tk0), .pred_target(tgt0), .pred_ghr(ghr0),
    .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .redirect_valid(rv0), .redirect_pc(rpc0)
`ifdef BTB_PREDICTOR_STATS_EN
    , .stat_branches(sb0), .stat_mispredicts(sm0), .stat_btb_misses(sx0)
`endif
  );

  btb_gshare_predictor #(.MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_hit(hit1), .pred_taken(tk1), .pred_target(tgt1), .pred_ghr(ghr1),
    .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .redirect_valid(rv1), .redirect_pc(rpc1)
`ifdef BTB_PREDICTOR_STATS_EN
    , .stat_branches(sb1), .stat_mispredicts(sm1), .stat_btb_misses(sx1)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; s selects which instance's lookup outputs are checked.
  task automatic vec(input bit s, input bit rst, input logic [31:0] fpc,
                     input bit v, input bit br, input logic [31:0] upc, input bit tk,
                     input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                     input logic [3:0] ughr, input bit eh, input bit et,
                     input logic [31:0] etgt, input logic [3:0] eg, input bit erv,
                     input logic [31:0] erpc);
    @(posedge clk);
    #1;
    rst_n = rst; fetch_pc = fpc; upd_valid = v; upd_is_branch = br; upd_pc = upc;
    upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    upd_ghr = ughr;
    exp_q.push_back({s, eh, et, etgt, eg, erv, erpc});
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL queue: check strobe with empty expected queue at %0t", $time);
      end else begin
        logic [EXP_W-1:0] e;
        logic             s;
        e = exp_q.pop_front();
        s = e[71];
        check(s ? "dut1.pred_hit"    : "dut0.pred_hit",    {31'd0, s ? hit1 : hit0}, {31'd0, e[70]});
        check(s ? "dut1.pred_taken"  : "dut0.pred_taken",  {31'd0, s ? tk1 : tk0},   {31'd0, e[69]});
        check(s ? "dut1.pred_target" : "dut0.pred_target", s ? tgt1 : tgt0,          e[68:37]);
        check(s ? "dut1.pred_ghr"    : "dut0.pred_ghr",    {28'd0, s ? ghr1 : ghr0}, {28'd0, e[36:33]});
        check("redirect_valid", {31'd0, s ? rv1 : rv0}, {31'd0, e[32]});
        check("redirect_pc", s ? rpc1 : rpc0, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fetch_pc = '0; upd_valid = 1'b0; upd_is_branch = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; upd_ghr = '0;
    repeat (3) @(posedge clk);

    //  s rst fpc     v br upc     tk tgt     ptk ptgt    ughr  eh et etgt    eg    erv erpc
    // post-reset lookup, then first allocation (read-before-write in the same cycle)
    vec(0, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h44, 4'h0, 0, 32'h0);
    vec(0, 1, 32'h40, 1, 1, 32'h40, 1, 32'h80, 0, 32'h44, 4'h0, 0, 0, 32'h44, 4'h0, 1, 32'h80);
    vec(0, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1, 1, 32'h80, 4'h1, 0, 32'h0);
    // gshare lookup of 0x40 with GHR=1 reads PHT[1], still weakly not-taken
    vec(1, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1, 0, 32'h44, 4'h1, 0, 32'h0);
    // three more taken resolutions: counter saturates at 3, GHR fills to F
    vec(0, 1, 32'h40, 1, 1, 32'h40, 1, 32'h80, 1, 32'h80, 4'h0, 1, 1, 32'h80, 4'h1, 0, 32'h80);
    vec(0, 1, 32'h40, 1, 1, 32'h40, 1, 32'h80, 1, 32'h80, 4'h0, 1, 1, 32'h80, 4'h3, 0, 32'h80);
    vec(0, 1, 32'h40, 1, 1, 32'h40, 1, 32'h80, 1, 32'h80, 4'h0, 1, 1, 32'h80, 4'h7, 0, 32'h80);
    vec(0, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1, 1, 32'h80, 4'hF, 0, 32'h0);
    vec(1, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1, 0, 32'h44, 4'hF, 0, 32'h0);
    // two not-taken resolutions predicted taken: redirect to pc+4, counter 3->1
    vec(0, 1, 32'h40, 1, 1, 32'h40, 0, 32'h80, 1, 32'h80, 4'hF, 1, 1, 32'h80, 4'hF, 1, 32'h44);
    vec(0, 1, 32'h40, 1, 1, 32'h40, 0, 32'h80, 1, 32'h80, 4'hF, 1, 1, 32'h80, 4'hE, 1, 32'h44);
    vec(0, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1, 0, 32'h44, 4'hC, 0, 32'h0);
    // not-taken non-BTB branch at 0x104 clears the GHR; no allocation
    vec(0, 1, 32'h40, 1, 1, 32'h104, 0, 32'h0, 0, 32'h0, 4'h0, 1, 0, 32'h44, 4'hC, 0, 32'h108);
    vec(0, 1, 32'h104, 1, 1, 32'h104, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h108, 4'h8, 0, 32'h108);
    // gshare PHT[0] was untouched by the upd_ghr=F updates (those went to PHT[F])
    vec(1, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1, 1, 32'h80, 4'h0, 0, 32'h0);
    // aliasing: 0x440 shares index 0 with 0x40, evicts it
    vec(0, 1, 32'h440, 1, 1, 32'h440, 1, 32'h200, 0, 32'h444, 4'h0, 0, 0, 32'h444, 4'h0, 1, 32'h200);
    vec(0, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h44, 4'h1, 0, 32'h0);
    vec(0, 1, 32'h440, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1, 1, 32'h200, 4'h1, 0, 32'h0);
    // taken with wrong predicted target: redirect and target rewrite
    vec(0, 1, 32'h440, 1, 1, 32'h440, 1, 32'h300, 1, 32'h200, 4'h0, 1, 1, 32'h200, 4'h1, 1, 32'h300);
    vec(0, 1, 32'h440, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1, 1, 32'h300, 4'h3, 0, 32'h0);
    // non-branch and invalid slot: no redirect, no state change
    vec(0, 1, 32'h440, 1, 0, 32'h440, 0, 32'h0, 1, 32'h300, 4'h0, 1, 1, 32'h300, 4'h3, 0, 32'h0);
    vec(0, 1, 32'h440, 0, 1, 32'h440, 0, 32'h0, 1, 32'h300, 4'h0, 1, 1, 32'h300, 4'h3, 0, 32'h0);
    vec(0, 1, 32'h440, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1, 1, 32'h300, 4'h3, 0, 32'h0);
    // reset in the same cycle as an allocating update: reset wins
    vec(0, 0, 32'h440, 1, 1, 32'h80, 1, 32'h500, 0, 32'h84, 4'h0, 1, 1, 32'h300, 4'h3, 1, 32'h500);
    vec(0, 1, 32'h80, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h84, 4'h0, 0, 32'h0);
`ifdef BTB_PREDICTOR_STATS_EN
    check("stat_branches", sb0, 32'd0);
    check("stat_mispredicts", sm0, 32'd0);
    check("stat_btb_misses", sx0, 32'd0);
`endif
    vec(0, 1, 32'h440, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h444, 4'h0, 0, 32'h0);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    upd_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
